// File: rtl/reg_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_tx
//  Snapshots rega/regb on request and sends them as four 8N1 UART bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dump_req,
    input  logic [15:0] rega,
    input  logic [15:0] regb,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [1:0]         r_state;
    logic [31:0]        r_shadow;
    logic [1:0]         r_byte_idx;
    logic [2:0]         r_bit_cnt;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    logic [7:0]         w_cur_byte;
    logic [2:0]         w_next_bit;
    logic               w_bit_end;

    always_comb begin
        w_cur_byte = r_shadow[31:24];
        case (r_byte_idx)
            2'd0:    w_cur_byte = r_shadow[31:24];
            2'd1:    w_cur_byte = r_shadow[23:16];
            2'd2:    w_cur_byte = r_shadow[15:8];
            default: w_cur_byte = r_shadow[7:0];
        endcase
    end

    assign w_next_bit = r_bit_cnt + 3'd1;
    assign w_bit_end  = (r_clk_cnt == c_bit_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_shadow   <= 32'd0;
            r_byte_idx <= 2'd0;
            r_bit_cnt  <= 3'd0;
            r_clk_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    // Also taken in the done cycle, so a held request chains dumps.
                    if (dump_req) begin
                        r_shadow   <= {rega, regb};
                        r_byte_idx <= 2'd0;
                        r_bit_cnt  <= 3'd0;
                        r_clk_cnt  <= '0;
                        r_state    <= c_st_start;
                        r_busy     <= 1'b1;
                        r_tx       <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= 3'd0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= c_st_data;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_bit_cnt <= w_next_bit;
                            r_tx      <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= c_st_start;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_tx
//  Self-checking bench for reg_dump_tx with CLKS_PER_BIT = 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dump_req;
    logic [15:0] rega;
    logic [15:0] regb;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_byte_q[$];
    logic       exp_tx_q[$];

    reg_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dump_req (dump_req),
        .rega     (rega),
        .regb     (regb),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_frame(input logic [15:0] ra, input logic [15:0] rb);
        exp_byte_q.push_back(ra[15:8]);
        exp_byte_q.push_back(ra[7:0]);
        exp_byte_q.push_back(rb[15:8]);
        exp_byte_q.push_back(rb[7:0]);
    endtask

    // Returns in cycle 1, i.e. just after the accepting edge.
    task automatic start_dump(input logic [15:0] ra, input logic [15:0] rb, input bit push);
        @(posedge clk); #1;
        rega = ra;
        regb = rb;
        dump_req = 1'b1;
        if (push) push_frame(ra, rb);
        @(posedge clk); #1;
        dump_req = 1'b0;
    endtask

    task automatic rx_bytes(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic [7:0] e;
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (tx !== 1'b0 && w < 300);
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL %s_start_timeout: got tx=%b expected start bit 0", tag, tx);
                return;
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL %s_start_mid: got tx=%b expected 0", tag, tx);
            end
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL %s_stop: got tx=%b expected 1", tag, tx);
            end
            checks++;
            if (exp_byte_q.size() == 0) begin
                errors++;
                $display("FAIL %s_byte: got %02h expected nothing (queue empty)", tag, b);
            end else begin
                e = exp_byte_q.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %02h expected %02h", tag, i, b, e);
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (done !== 1'b1 && w < 300);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got done=%b busy=%b expected done=1 busy=0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dump_req = 1'b1;
        rega = 16'hC3E1;
        regb = 16'h7E81;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done);
            end
        end
        push_frame(16'hC3E1, 16'h7E81);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got tx=%b busy=%b expected 1 0", tx, busy);
        end
        @(posedge clk); #1;
        dump_req = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_start: got tx=%b busy=%b expected 0 1", tx, busy);
        end
        rx_bytes(4, "reset");
        wait_done("reset");
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h0F; bytes[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) exp_tx_q.push_back(1'b0);
            for (int k = 0; k < 8; k++) repeat (CPB) exp_tx_q.push_back(bytes[i][k]);
            repeat (CPB) exp_tx_q.push_back(1'b1);
        end
        start_dump(16'hA55A, 16'h0F01, 1'b0);
        for (int c = 1; c <= 160; c++) begin
            logic e;
            @(negedge clk);
            e = exp_tx_q.pop_front();
            checks++;
            if (tx !== e || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_cycle%0d: got tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                         c, tx, busy, done, e);
            end
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_cycle161: got tx=%b busy=%b done=%b expected 1 0 1", tx, busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_snapshot();
        start_dump(16'h1234, 16'h5678, 1'b1);
        fork
            begin
                repeat (9) @(posedge clk);
                #1;
                rega = 16'hFFFF;
                regb = 16'hFFFF;
            end
            rx_bytes(4, "snapshot");
        join
        wait_done("snapshot");
    endtask

    task automatic test_ignored();
        int dn;
        dn = 0;
        start_dump(16'h8001, 16'h3CC3, 1'b1);
        fork
            begin
                repeat (19) @(posedge clk);
                #1 dump_req = 1'b1;
                @(posedge clk); #1 dump_req = 1'b0;
                repeat (79) @(posedge clk);
                #1 dump_req = 1'b1;
                @(posedge clk); #1 dump_req = 1'b0;
            end
            rx_bytes(4, "ignored");
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
            end
        join
        checks++;
        if (dn != 1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL ignored_single: got done_pulses=%0d busy=%b tx=%b expected 1 0 1", dn, busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        int  dn;
        bit  prev;
        dn = 0;
        prev = 1'b0;
        @(posedge clk); #1;
        rega = 16'h1234;
        regb = 16'h5678;
        dump_req = 1'b1;
        // Acceptances at edges 0, 161 and 322 fall inside the 400-cycle hold.
        repeat (3) push_frame(16'h1234, 16'h5678);
        fork
            begin
                repeat (400) @(posedge clk);
                #1 dump_req = 1'b0;
            end
            rx_bytes(12, "b2b");
            for (int c = 0; c < 520; c++) begin
                @(negedge clk);
                if (prev && dn <= 2) begin
                    checks++;
                    if (tx !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_restart%0d: got tx=%b busy=%b expected 0 1", dn, tx, busy);
                    end
                end
                prev = 1'b0;
                if (done === 1'b1) begin
                    dn++;
                    prev = 1'b1;
                    checks++;
                    if (tx !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_done_tx%0d: got tx=%b expected 1", dn, tx);
                    end
                end
            end
        join
        checks++;
        if (dn != 3) begin
            errors++;
            $display("FAIL b2b_frames: got %0d done pulses expected 3", dn);
        end
    endtask

    task automatic test_mid_reset();
        start_dump(16'h0000, 16'h0000, 1'b0);
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done);
        end
        start_dump(16'hBEEF, 16'h6D21, 1'b1);
        rx_bytes(4, "midreset");
        wait_done("midreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_ignored();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (exp_byte_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d bytes left expected 0", exp_byte_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
